// File: rtl/cpu_pkg.sv
// Shared types and widths for the RAM loader, the dual-clock RAM and the read stage.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WRITE   = 3'd4,
        RECOVER = 3'd5
    } loader_state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam int   RAM_ADDR_W = 10;
    localparam int   RAM_DATA_W = 8;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchroniser, baud counter and deserialiser FSM.
// byte_valid and frame_err are single-cycle strobes issued as the stop bit is sampled.
module uart_rx_core
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 8
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              rx,
    output logic              byte_valid,
    output logic [DATA_W-1:0] byte_data,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic                rx_meta_r;
    logic                rx_sync_r;
    loader_state_t       state_r;
    loader_state_t       state_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nx_s;
    logic [BIT_W-1:0]    bit_idx_r;
    logic [BIT_W-1:0]    bit_idx_nx_s;
    logic [DATA_W-1:0]   shift_r;
    logic [DATA_W-1:0]   shift_nx_s;

    // Two-flop synchroniser for the asynchronous rx line, reset to line-idle.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            rx_meta_r <= UART_IDLE;
            rx_sync_r <= UART_IDLE;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // FSM state, baud counter, bit index and shift register.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_idx_r <= '0;
            shift_r   <= '0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            bit_idx_r <= bit_idx_nx_s;
            shift_r   <= shift_nx_s;
        end
    end

    // Next-state logic; counter restarts at every bit boundary so timing never drifts.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r + CNT_ONE;
        bit_idx_nx_s = bit_idx_r;
        shift_nx_s   = shift_r;
        byte_valid   = 1'b0;
        frame_err    = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nx_s = '0;
                if (rx_sync_r != UART_IDLE) begin
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_nx_s     = '0;
                    bit_idx_nx_s = '0;
                    state_nx_s   = (rx_sync_r == UART_IDLE) ? IDLE : DATA;
                end else begin
                    state_nx_s = START;
                end
            end
            DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_nx_s   = '0;
                    shift_nx_s = {rx_sync_r, shift_r[DATA_W-1:1]};
                    if (bit_idx_r == BIT_LAST) begin
                        state_nx_s = STOP;
                    end else begin
                        bit_idx_nx_s = bit_idx_r + BIT_ONE;
                    end
                end else begin
                    state_nx_s = DATA;
                end
            end
            STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_nx_s = '0;
                    if (rx_sync_r == UART_IDLE) begin
                        byte_valid = 1'b1;
                        state_nx_s = WRITE;
                    end else begin
                        frame_err  = 1'b1;
                        state_nx_s = RECOVER;
                    end
                end else begin
                    state_nx_s = STOP;
                end
            end
            WRITE: begin
                cnt_nx_s   = '0;
                state_nx_s = IDLE;
            end
            RECOVER: begin
                // A held-low break must end before a new start edge is accepted.
                cnt_nx_s = '0;
                if (rx_sync_r == UART_IDLE) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RECOVER;
                end
            end
            default: begin
                cnt_nx_s   = '0;
                state_nx_s = IDLE;
            end
        endcase
    end

    assign byte_data = shift_r;

endmodule

// File: rtl/uart_ram_loader.sv
// Loads a UART byte stream sequentially into RAM port A, one write strobe per byte,
// stopping once LOAD_LEN bytes have been written.
module uart_ram_loader
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int DATA_W       = RAM_DATA_W,
    parameter int LOAD_LEN     = 1024
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              rx,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dia,
    output logic [ADDR_W:0]   byte_count,
    output logic              done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LEN_M1  = (ADDR_W + 1)'(LOAD_LEN - 1);

    logic              byte_valid_s;
    logic [DATA_W-1:0] byte_data_s;
    logic              frame_err_s;
    logic [ADDR_W-1:0] ptr_r;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_W       (DATA_W)
    ) u_rx (
        .clka       (clka),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .frame_err  (frame_err_s)
    );

    // Write strobe, pointer and load bookkeeping; the strobe coincides with the core's WRITE state.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            ena        <= 1'b0;
            wea        <= 1'b0;
            addra      <= '0;
            dia        <= '0;
            byte_count <= '0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            ptr_r      <= '0;
        end else begin
            frame_err <= frame_err_s;
            if (byte_valid_s && !done) begin
                ena   <= 1'b1;
                wea   <= 1'b1;
                addra <= ptr_r;
                dia   <= byte_data_s;
            end else begin
                ena <= 1'b0;
                wea <= 1'b0;
            end
            // Bookkeeping advances as the strobe retires, i.e. when the RAM has taken the byte.
            if (ena) begin
                ptr_r      <= ptr_r + PTR_ONE;
                byte_count <= byte_count + CNT_ONE;
                if (byte_count == LEN_M1) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Self-checking bench for uart_ram_loader: frame table plus hand-written reset/glitch sequences.
module tb_uart_ram_loader;

    localparam int CPB = 16;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic        do_rst;
        int          gap;
        logic [7:0]  data;
        logic        stop_bit;
        int          hold_low;
        logic        exp_wr;
        logic [9:0]  exp_addr;
        logic [10:0] exp_cnt;
        logic        exp_done;
        int          exp_ferr;
    } vec_t;

    logic        clka = 1'b0;
    logic        rst  = 1'b0;
    logic        rx   = 1'b1;
    logic        ena, wea, done, frame_err;
    logic [9:0]  addra;
    logic [7:0]  dia;
    logic [10:0] byte_count;

    int  n_chk    = 0;
    int  n_fail   = 0;
    int  ferr_cnt = 0;
    logic prev_ena  = 1'b0;
    logic prev_ferr = 1'b0;
    wr_t exp_q[$];
    logic [7:0] mem [0:1023];

    uart_ram_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (10),
        .DATA_W       (8),
        .LOAD_LEN     (4)
    ) dut (
        .clka       (clka),
        .rst        (rst),
        .rx         (rx),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dia        (dia),
        .byte_count (byte_count),
        .done       (done),
        .frame_err  (frame_err)
    );

    always #5 clka = ~clka;

    // RAM port A model
    always @(posedge clka) begin
        if (ena && wea) mem[addra] <= dia;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Strobe scoreboard and frame_err pulse monitor, sampled away from the active edge.
    always @(negedge clka) begin
        if (!rst) begin
            if (ena || wea) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: addra=%0h dia=%0h, expected no strobe", addra, dia);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (!(ena && wea && !prev_ena && addra == e.addr && dia == e.data)) begin
                        n_fail++;
                        $display("FAIL strobe: ena=%0b wea=%0b prev=%0b addra=%0h dia=%0h, expected 1-cycle strobe addra=%0h dia=%0h",
                                 ena, wea, prev_ena, addra, dia, e.addr, e.data);
                    end
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                n_chk++;
                if (prev_ferr) begin
                    n_fail++;
                    $display("FAIL frame_err_width: high for 2+ cycles, expected 1");
                end
            end
        end
        prev_ena  = ena;
        prev_ferr = frame_err;
    end

    task automatic apply_reset();
        #2 rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clka);
        check("rst_outputs", {ena, wea, addra, dia, byte_count, done, frame_err}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clka);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clka);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int hold_low);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_b);
        if (!stop_b) begin
            rx = 1'b0;
            repeat (hold_low) @(negedge clka);
        end
        rx = 1'b1;
    endtask

    initial begin
        vec_t vecs [11];
        int   f0;
        vecs[0]  = '{1'b0, 4, 8'hA5, 1'b1, 0,  1'b1, 10'd0, 11'd1, 1'b0, 0};
        vecs[1]  = '{1'b1, 4, 8'h01, 1'b1, 0,  1'b1, 10'd0, 11'd1, 1'b0, 0};
        vecs[2]  = '{1'b0, 0, 8'h02, 1'b1, 0,  1'b1, 10'd1, 11'd2, 1'b0, 0};
        vecs[3]  = '{1'b0, 0, 8'h03, 1'b1, 0,  1'b1, 10'd2, 11'd3, 1'b0, 0};
        vecs[4]  = '{1'b1, 4, 8'h55, 1'b0, 40, 1'b0, 10'd0, 11'd0, 1'b0, 1};
        vecs[5]  = '{1'b0, 4, 8'h66, 1'b1, 0,  1'b1, 10'd0, 11'd1, 1'b0, 0};
        vecs[6]  = '{1'b1, 4, 8'h10, 1'b1, 0,  1'b1, 10'd0, 11'd1, 1'b0, 0};
        vecs[7]  = '{1'b0, 4, 8'h11, 1'b1, 0,  1'b1, 10'd1, 11'd2, 1'b0, 0};
        vecs[8]  = '{1'b0, 4, 8'h12, 1'b1, 0,  1'b1, 10'd2, 11'd3, 1'b0, 0};
        vecs[9]  = '{1'b0, 4, 8'h13, 1'b1, 0,  1'b1, 10'd3, 11'd4, 1'b1, 0};
        vecs[10] = '{1'b0, 4, 8'h14, 1'b1, 0,  1'b0, 10'd0, 11'd4, 1'b1, 0};

        @(negedge clka);
        apply_reset();
        repeat (100) @(negedge clka);
        check("idle_count", 32'(byte_count), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        // Short low glitch must be rejected without side effects.
        rx = 1'b0;
        repeat (4) @(negedge clka);
        rx = 1'b1;
        repeat (30) @(negedge clka);
        check("glitch_count", 32'(byte_count), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_rst) apply_reset();
            repeat (vecs[i].gap) @(negedge clka);
            f0 = ferr_cnt;
            if (vecs[i].exp_wr) exp_q.push_back('{vecs[i].exp_addr, vecs[i].data});
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].hold_low);
            repeat (2) @(negedge clka);
            check($sformatf("v%0d_count", i), 32'(byte_count), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_pending", i), 32'(exp_q.size()), 32'd0);
            if (vecs[i].exp_wr)
                check($sformatf("v%0d_ram", i), 32'(mem[vecs[i].exp_addr]), 32'(vecs[i].data));
        end

        // Reset in the middle of data bit 4 of 0x3C aborts the frame.
        repeat (4) @(negedge clka);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h3C >> i));
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clka);
        apply_reset();
        repeat (20) @(negedge clka);
        check("midrst_count", 32'(byte_count), 32'd0);
        exp_q.push_back('{10'd0, 8'h77});
        send_frame(8'h77, 1'b1, 0);
        repeat (2) @(negedge clka);
        check("midrst_final_count", 32'(byte_count), 32'd1);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        check("midrst_ram", 32'(mem[0]), 32'h77);
        check("midrst_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
